memwb_skid_stage: RTL and testbench
===================================

// Module: memwb_skid_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
//  Sits between the data-memory stage and register-file writeback.
//  Supports stall via out_ready backpressure and flush via bubble insertion.
//  in_ready is registered, giving full throughput with no combinational ready path.
// PARAMETERS
//  DATA_W      32  width of ALU result, memory read data and writeback data
//  REG_ADDR_W  5   width of destination register index
// PORTS
//  clk            in   1           clock; all state updates on rising edge
//  rst_n          in   1           asynchronous active-low reset
//  flush          in   1           synchronous kill of all held and incoming entries
//  in_valid       in   1           upstream entry valid
//  in_ready       out  1           stage can accept an entry (registered)
//  in_regWrite    in   1           upstream register-write enable
//  in_memToReg    in   1           1: writeback selects readData; 0: selects aluResult
//  in_aluResult   in   DATA_W      ALU result
//  in_readData    in   DATA_W      data-memory read value
//  in_writeReg    in   REG_ADDR_W  destination register index
//  out_valid      out  1           output entry valid
//  out_ready      in   1           writeback consumes output this cycle
//  out_regWrite   out  1           register-write enable, forced 0 whenever out_valid=0
//  out_memToReg   out  1           registered memToReg
//  out_aluResult  out  DATA_W      registered ALU result
//  out_readData   out  DATA_W      registered read data
//  out_writeReg   out  REG_ADDR_W  registered destination index
//  out_wbData     out  DATA_W      registered writeback value, mux resolved at load
// BEHAVIOUR
//  - Accept = in_valid & in_ready. Consume = out_valid & out_ready.
//  - Storage: main entry (drives out_*) and skid entry. FIFO order is always preserved.
//  - wbData = memToReg ? readData : aluResult, computed when an entry is written.
//  - State EMPTY (main invalid): on accept, load main and go to ONE.
//  - State ONE (main valid, skid empty):
//      consume & accept -> main<=in, stay ONE
//      consume only -> EMPTY
//      accept only -> skid<=in, go to FULL
//      neither -> hold
//  - State FULL (main and skid valid): in_ready=0.
//      consume -> main<=skid, go to ONE
//      no consume -> hold
//  - in_ready is registered: equals 1 exactly when the next state is not FULL.
//  - Latency: 1 cycle from accept to out_valid when empty.
//    Throughput: 1 entry/cycle while out_ready=1.
//  - flush (highest priority, synchronous):
//      next cycle out_valid=0, skid empty, in_ready=1, state EMPTY
//      an entry presented in the flush cycle is discarded
//      a consume in the flush cycle still completes
//      data fields hold; out_regWrite reads 0
//  - out_valid=0 -> out_regWrite=0 regardless of stored value.
//    Other out_* fields hold their last value.
//  - Reset (async assert, sync deassert expected upstream):
//      out_valid=0, in_ready=1, state EMPTY
//      all out_* data and control fields = 0
//      reset mid-transfer drops all entries
//  - in_valid while in_ready=0 is ignored; upstream must hold its entry.
// CONFIGURATION
//  MEMWB_ZERO_REG_SQUASH_EN
//    defined: an accepted entry with writeReg==0 stores regWrite=0 in main and skid;
//      wbData is still computed.
//    undefined: regWrite is stored as presented.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> out_valid=0, out_regWrite=0, in_ready=1, all data out=0.
//  2. Streaming: out_ready=1, 4 entries aluResult=0x10..0x13, memToReg=0
//       -> out_wbData=0x10..0x13 on consecutive cycles, 1-cycle latency.
//  3. Stall: out_ready=0 with 3 entries offered -> 2 stored, in_ready=0 after the 2nd;
//       third is held upstream; release -> order 1,2,3, no loss or duplicate.
//  4. Writeback mux: memToReg=1, readData=0xDEADBEEF, aluResult=0x4 -> out_wbData=0xDEADBEEF.
//  5. Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0,
//       out_regWrite=0, in_ready=1; flushed and incoming entries never appear.
//  6. MEMWB_ZERO_REG_SQUASH_EN: writeReg=0, regWrite=1 -> out_regWrite=0 when defined,
//       =1 when undefined.

Source files
------------

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage: valid/ready handshake, 2-entry skid buffer, registered in_ready, flush.
// Optional MEMWB_ZERO_REG_SQUASH_EN: entries targeting register 0 are stored with regWrite cleared.
module memwb_skid_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_regWrite,
    input  logic                  in_memToReg,
    input  logic [DATA_W-1:0]     in_aluResult,
    input  logic [DATA_W-1:0]     in_readData,
    input  logic [REG_ADDR_W-1:0] in_writeReg,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_regWrite,
    output logic                  out_memToReg,
    output logic [DATA_W-1:0]     out_aluResult,
    output logic [DATA_W-1:0]     out_readData,
    output logic [REG_ADDR_W-1:0] out_writeReg,
    output logic [DATA_W-1:0]     out_wbData
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef struct packed {
        logic                  regWrite;
        logic                  memToReg;
        logic [DATA_W-1:0]     aluResult;
        logic [DATA_W-1:0]     readData;
        logic [DATA_W-1:0]     wbData;
        logic [REG_ADDR_W-1:0] writeReg;
    } entry_t;

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    entry_t     main_q, main_d;
    entry_t     skid_q, skid_d;
    entry_t     in_entry;
    logic       accept;
    logic       consume;
    logic       main_vld;

    function automatic logic [DATA_W-1:0] wb_select(
        input logic              mem_to_reg,
        input logic [DATA_W-1:0] read_data,
        input logic [DATA_W-1:0] alu_result
    );
        return mem_to_reg ? read_data : alu_result;
    endfunction

    function automatic logic reg_write_filter(
        input logic                  reg_write,
        input logic [REG_ADDR_W-1:0] write_reg
    );
`ifdef MEMWB_ZERO_REG_SQUASH_EN
        return reg_write & (write_reg != '0);
`else
        logic unused_wr;
        unused_wr = ^write_reg;
        return reg_write | (unused_wr & 1'b0);
`endif
    endfunction

    // Writeback mux resolved once, when the entry enters storage.
    always_comb begin
        in_entry.regWrite  = reg_write_filter(in_regWrite, in_writeReg);
        in_entry.memToReg  = in_memToReg;
        in_entry.aluResult = in_aluResult;
        in_entry.readData  = in_readData;
        in_entry.wbData    = wb_select(in_memToReg, in_readData, in_aluResult);
        in_entry.writeReg  = in_writeReg;
    end

    assign main_vld = (state_q == ST_ONE) || (state_q == ST_FULL);
    assign accept   = in_valid & in_ready_q;
    assign consume  = main_vld & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    main_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (consume && accept) begin
                    main_d = in_entry;
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end else if (accept) begin
                    skid_d  = in_entry;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (consume) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush kills everything but leaves data fields untouched.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = main_vld;
    assign out_regWrite  = main_vld & main_q.regWrite;
    assign out_memToReg  = main_q.memToReg;
    assign out_aluResult = main_q.aluResult;
    assign out_readData  = main_q.readData;
    assign out_writeReg  = main_q.writeReg;
    assign out_wbData    = main_q.wbData;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Scoreboard bench for memwb_skid_stage: directed scenarios followed by random traffic,
// checked against a queue model of a 2-deep FIFO with flush and reset.
module tb_memwb_skid_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_regWrite;
    logic        in_memToReg;
    logic [31:0] in_aluResult;
    logic [31:0] in_readData;
    logic [4:0]  in_writeReg;
    logic        out_valid;
    logic        out_ready;
    logic        out_regWrite;
    logic        out_memToReg;
    logic [31:0] out_aluResult;
    logic [31:0] out_readData;
    logic [4:0]  out_writeReg;
    logic [31:0] out_wbData;

    memwb_skid_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regWrite(in_regWrite), .in_memToReg(in_memToReg),
        .in_aluResult(in_aluResult), .in_readData(in_readData), .in_writeReg(in_writeReg),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_regWrite(out_regWrite), .out_memToReg(out_memToReg),
        .out_aluResult(out_aluResult), .out_readData(out_readData),
        .out_writeReg(out_writeReg), .out_wbData(out_wbData)
    );

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] wb;
        logic [4:0]  wr;
    } exp_t;

    exp_t sb[$];
    exp_t last_e;
    exp_t mon_e;
    bit   mdl_ready;
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: outputs are sampled mid-cycle and compared against the model front.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("rst_regWrite", {31'd0, out_regWrite}, 32'd0);
            chk("rst_wbData", out_wbData, 32'd0);
            chk("rst_alu", out_aluResult, 32'd0);
            chk("rst_rd", out_readData, 32'd0);
            chk("rst_wr_m2r", {26'd0, out_memToReg, out_writeReg}, 32'd0);
            sb.delete();
            last_e    = '{rw: 1'b0, m2r: 1'b0, alu: 32'd0, rd: 32'd0, wb: 32'd0, wr: 5'd0};
            mdl_ready = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, sb.size() < 2});
            chk("out_valid", {31'd0, out_valid}, {31'd0, sb.size() != 0});
            if (sb.size() != 0) begin
                mon_e  = sb[0];
                last_e = mon_e;
                chk("out_regWrite", {31'd0, out_regWrite}, {31'd0, mon_e.rw});
            end else begin
                mon_e = last_e;
                chk("idle_regWrite", {31'd0, out_regWrite}, 32'd0);
            end
            chk("out_wbData", out_wbData, mon_e.wb);
            chk("out_aluResult", out_aluResult, mon_e.alu);
            chk("out_readData", out_readData, mon_e.rd);
            chk("out_wr_m2r", {26'd0, out_memToReg, out_writeReg}, {26'd0, mon_e.m2r, mon_e.wr});
            mdl_ready = (sb.size() < 2);
            if (sb.size() != 0 && out_ready) void'(sb.pop_front());
            if (flush) sb.delete();
        end
    end

    // One clock of stimulus; the expected entry is queued when the model says it is accepted.
    task automatic cyc(input bit v, input bit rw, input bit m2r, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [4:0] wr, input bit ordy, input bit fl);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid     = v;
        in_regWrite  = rw;
        in_memToReg  = m2r;
        in_aluResult = alu;
        in_readData  = rd;
        in_writeReg  = wr;
        out_ready    = ordy;
        flush        = fl;
        @(negedge clk);
        #1;
        if (rst_n && v && mdl_ready && !fl) begin
            e.rw  = rw;
`ifdef MEMWB_ZERO_REG_SQUASH_EN
            if (wr == 5'd0) e.rw = 1'b0;
`endif
            e.m2r = m2r;
            e.alu = alu;
            e.rd  = rd;
            e.wb  = m2r ? rd : alu;
            e.wr  = wr;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, ordy, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_regWrite = 1'b0;
        in_memToReg = 1'b0;
        in_aluResult = '0;
        in_readData = '0;
        in_writeReg = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2, 1'b1);

        // Streaming with the consumer always ready.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 1'b1, 1'b0, 32'h10 + 32'(i), $urandom, 5'(i + 1), 1'b1, 1'b0);
        idle(3, 1'b1);

        // Stall: two stored, third held upstream, then drained in order.
        cyc(1'b1, 1'b1, 1'b0, 32'hA1, 32'h0, 5'd1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hA2, 32'h0, 5'd2, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hA3, 32'h0, 5'd3, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hA3, 32'h0, 5'd3, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hA3, 32'h0, 5'd3, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Writeback mux selects read data.
        cyc(1'b1, 1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Flush from FULL with an incoming entry, then flush while consuming.
        cyc(1'b1, 1'b1, 1'b0, 32'hB1, 32'h0, 5'd4, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'hB2, 32'h55, 5'd5, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hB3, 32'h0, 5'd6, 1'b0, 1'b1);
        idle(2, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 32'hC1, 32'h0, 5'd8, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 32'hC2, 32'h0, 5'd9, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Destination register zero with regWrite set.
        cyc(1'b1, 1'b1, 1'b0, 32'hD0, 32'h0, 5'd0, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Reset asserted asynchronously with entries held.
        cyc(1'b1, 1'b1, 1'b0, 32'hE1, 32'h1, 5'd10, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'hE2, 32'h2, 5'd11, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_wbData", out_wbData, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2, 1'b1);

        // Random traffic with backpressure and occasional flushes.
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        idle(4, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
